// File: rtl/checker_mon.sv
// Per-channel result checker: y must equal a|b on every enabled channel. Counts
// passing/failing samples, captures the first failure and gates channels via a delayed control FSM.
module checker_mon #(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int CNT_W  = 16,
  parameter int DLY_W  = 8,
  parameter int RST_ON = 1,
  localparam int CH_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               smp_valid,
  input  logic [N*W-1:0]     a,
  input  logic [N*W-1:0]     b,
  input  logic [N*W-1:0]     y,
  input  logic               ctl_valid,
  output logic               ctl_ready,
  input  logic [1:0]         ctl_op,
  input  logic [N-1:0]       ctl_mask,
  input  logic [DLY_W-1:0]   ctl_dly,
  output logic [N-1:0]       ena,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               err_sticky,
  output logic               ff_valid,
  output logic [CH_W-1:0]    ff_ch,
  output logic [CNT_W-1:0]   ff_time
);

  localparam logic [N-1:0] ENA_RST = (RST_ON != 0) ? {N{1'b1}} : {N{1'b0}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic [N-1:0]       r_ena;
  logic [1:0]         r_op;
  logic [N-1:0]       r_mask;
  logic [DLY_W-1:0]   r_dly;
  logic [CNT_W-1:0]   r_tstamp;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_fail_cnt;
  logic               r_err;
  logic               r_ff_valid;
  logic [CH_W-1:0]    r_ff_ch;
  logic [CNT_W-1:0]   r_ff_time;

  logic [N-1:0]       w_fail_vec;
  logic [CH_W-1:0]    w_ff_idx;
  logic               w_onoff;
  logic               w_clear;

  function automatic logic [N-1:0] f_apply(input logic [1:0] op, input logic [N-1:0] mask,
                                           input logic [N-1:0] cur);
    case (op)
      2'b01:   f_apply = cur | mask;
      2'b10:   f_apply = cur & ~mask;
      default: f_apply = cur;
    endcase
  endfunction

  assign w_onoff = (ctl_op == 2'b01) || (ctl_op == 2'b10);
  assign w_clear = ctl_valid && (r_state == S_IDLE) && (ctl_op == 2'b11);

  // Per-channel miscompare on enabled channels, and the lowest failing index
  always_comb begin
    w_fail_vec = '0;
    w_ff_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_fail_vec[i] = r_ena[i] && (y[i*W +: W] != (a[i*W +: W] | b[i*W +: W]));
    end
    for (int i = N - 1; i >= 0; i--) begin
      w_ff_idx = w_fail_vec[i] ? CH_W'(i) : w_ff_idx;
    end
  end

  // Control FSM: immediate or delayed enable/disable of channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_ena   <= ENA_RST;
      r_op    <= 2'b00;
      r_mask  <= '0;
      r_dly   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctl_valid && w_onoff) begin
            if (ctl_dly == '0) begin
              r_ena <= f_apply(ctl_op, ctl_mask, r_ena);
            end else begin
              // counts remaining edges after the next one, so the update lands at accept+D
              r_op    <= ctl_op;
              r_mask  <= ctl_mask;
              r_dly   <= ctl_dly - DLY_W'(1);
              r_state <= S_WAIT;
              r_ready <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (r_dly == '0) begin
            r_ena   <= f_apply(r_op, r_mask, r_ena);
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_dly <= r_dly - DLY_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Free-running timestamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tstamp <= '0;
    end else begin
      r_tstamp <= r_tstamp + CNT_W'(1);
    end
  end

  // Sample scoring, first-fail capture and clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_ff_valid <= 1'b0;
      r_ff_ch    <= '0;
      r_ff_time  <= '0;
    end else if (w_clear) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_ff_valid <= 1'b0;
      r_ff_ch    <= '0;
      r_ff_time  <= '0;
    end else if (smp_valid && (|r_ena)) begin
      if (|w_fail_vec) begin
        if (r_fail_cnt != '1) begin
          r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        end
        r_err <= 1'b1;
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_ch    <= w_ff_idx;
          r_ff_time  <= r_tstamp;
        end
      end else if (r_pass_cnt != '1) begin
        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end
    end
  end

  assign ctl_ready  = r_ready;
  assign ena        = r_ena;
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign err_sticky = r_err;
  assign ff_valid   = r_ff_valid;
  assign ff_ch      = r_ff_ch;
  assign ff_time    = r_ff_time;

endmodule

// File: tb/tb_checker_mon.sv
// Directed bench for checker_mon: default-size instance plus a CNT_W=4 instance for saturation/wrap.
module tb_checker_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic        smp_valid;
  logic [31:0] a, b, y;
  logic        ctl_valid;
  logic        ctl_ready;
  logic [1:0]  ctl_op;
  logic [3:0]  ctl_mask;
  logic [7:0]  ctl_dly;
  logic [3:0]  ena;
  logic [15:0] pass_cnt, fail_cnt, ff_time;
  logic        err_sticky, ff_valid;
  logic [1:0]  ff_ch;

  logic        rst4;
  logic        smp4;
  logic [31:0] a4, b4, y4;
  logic        ctl_valid4;
  logic        ctl_ready4;
  logic [1:0]  ctl_op4;
  logic [3:0]  ctl_mask4;
  logic [7:0]  ctl_dly4;
  logic [3:0]  ena4;
  logic [3:0]  pass4, fail4, ff_time4;
  logic        err4, ff_valid4;
  logic [1:0]  ff_ch4;

  int n_vec = 0;
  int n_mis = 0;
  int ts    = 0;
  int ts4   = 0;
  int ts_save;

  always #5 clk = ~clk;

  checker_mon #(.N(4), .W(8), .CNT_W(16), .DLY_W(8), .RST_ON(1)) dut (
    .clk(clk), .rst(rst), .smp_valid(smp_valid), .a(a), .b(b), .y(y),
    .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_op(ctl_op), .ctl_mask(ctl_mask),
    .ctl_dly(ctl_dly), .ena(ena), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_sticky(err_sticky), .ff_valid(ff_valid), .ff_ch(ff_ch), .ff_time(ff_time)
  );

  checker_mon #(.N(4), .W(8), .CNT_W(4), .DLY_W(8), .RST_ON(1)) dut4 (
    .clk(clk), .rst(rst4), .smp_valid(smp4), .a(a4), .b(b4), .y(y4),
    .ctl_valid(ctl_valid4), .ctl_ready(ctl_ready4), .ctl_op(ctl_op4), .ctl_mask(ctl_mask4),
    .ctl_dly(ctl_dly4), .ena(ena4), .pass_cnt(pass4), .fail_cnt(fail4),
    .err_sticky(err4), .ff_valid(ff_valid4), .ff_ch(ff_ch4), .ff_time(ff_time4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ts++;
    ts4++;
  endtask

  task automatic smp(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] iy);
    smp_valid = 1'b1; a = ia; b = ib; y = iy;
    step();
    smp_valid = 1'b0; a = '0; b = '0; y = '0;
  endtask

  task automatic ctl(input logic [1:0] op, input logic [3:0] mask, input logic [7:0] dly);
    ctl_valid = 1'b1; ctl_op = op; ctl_mask = mask; ctl_dly = dly;
    step();
    ctl_valid = 1'b0; ctl_op = 2'b00; ctl_mask = '0; ctl_dly = '0;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] ep, input logic [15:0] ef);
    chk({tag, "_pass"}, pass_cnt, ep);
    chk({tag, "_fail"}, fail_cnt, ef);
  endtask

  initial begin
    rst = 1'b1; smp_valid = 1'b0; a = '0; b = '0; y = '0;
    ctl_valid = 1'b0; ctl_op = 2'b00; ctl_mask = '0; ctl_dly = '0;
    rst4 = 1'b1; smp4 = 1'b0; a4 = '0; b4 = '0; y4 = '0;
    ctl_valid4 = 1'b0; ctl_op4 = 2'b00; ctl_mask4 = '0; ctl_dly4 = '0;

    step(); step();
    chk("rst_ready", ctl_ready, 1);
    chk("rst_ena", ena, 4'hF);
    chk_cnt("rst", 0, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_ffv", ff_valid, 0);
    chk("rst_fft", ff_time, 0);
    rst = 1'b0; ts = 0;

    // all channels correct
    smp(32'h1234_5678, 32'h8070_0A01, 32'h9274_5E79);
    chk_cnt("first_smp", 1, 0);
    smp(32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF);
    smp(32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    smp(32'hA5A5_A5A5, 32'h5A5A_0000, 32'hFFFF_A5A5);
    chk_cnt("pass4", 4, 0);
    chk("pass4_err", err_sticky, 0);

    // channel 1 disabled: its corruption is ignored
    ctl(2'b10, 4'b0010, 8'd0);
    chk("off_ch1_ena", ena, 4'b1101);
    smp(32'h0, 32'h0, 32'h0000_FF00);
    smp(32'h0, 32'h0, 32'h0000_FF00);
    smp(32'h0, 32'h0, 32'h0000_FF00);
    chk_cnt("ch1_ignored", 7, 0);
    ctl(2'b01, 4'b0010, 8'd0);
    chk("on_ch1_ena", ena, 4'hF);
    ts_save = ts;
    smp(32'h0, 32'h0, 32'h0000_FF00);
    chk_cnt("ch1_fail", 7, 1);
    chk("ch1_ffv", ff_valid, 1);
    chk("ch1_ffch", ff_ch, 1);
    chk("ch1_fft", ff_time, 32'(ts_save));
    chk("ch1_err", err_sticky, 1);

    // delayed off-all at tstamp 10
    chk("ts_is_10", ts, 10);
    ctl(2'b10, 4'b1111, 8'd5);
    chk("wait_rdy11", ctl_ready, 0);
    chk("wait_ena11", ena, 4'hF);
    step();
    chk("wait_rdy12", ctl_ready, 0);
    ctl(2'b11, 4'hF, 8'd0);
    chk("wait_drop_rdy", ctl_ready, 0);
    chk_cnt("wait_drop", 7, 1);
    step();
    chk("wait_rdy14", ctl_ready, 0);
    smp(32'h0, 32'h0, 32'h0);
    chk_cnt("smp_c14", 8, 1);
    chk("wait_rdy15", ctl_ready, 0);
    chk("wait_ena15", ena, 4'hF);
    step();
    chk("dly_ena0", ena, 4'h0);
    chk("dly_rdy", ctl_ready, 1);
    smp(32'h0, 32'h0, 32'hFFFF_FFFF);
    chk_cnt("none_enabled", 8, 1);

    // nop, zero mask with delay, idempotent on/off
    ctl(2'b00, 4'hF, 8'd0);
    chk("nop_ena", ena, 4'h0);
    chk("nop_rdy", ctl_ready, 1);
    ctl(2'b01, 4'b0000, 8'd2);
    chk("zmask_rdy", ctl_ready, 0);
    step();
    step();
    chk("zmask_done_rdy", ctl_ready, 1);
    chk("zmask_ena", ena, 4'h0);
    ctl(2'b01, 4'b1111, 8'd0);
    ctl(2'b01, 4'b0001, 8'd0);
    chk("on_idem", ena, 4'hF);
    ctl(2'b10, 4'b0100, 8'd0);
    ctl(2'b10, 4'b0100, 8'd0);
    chk("off_idem", ena, 4'b1011);

    // enable lands on the same edge as a ch2 corruption: old enable applies
    ctl_valid = 1'b1; ctl_op = 2'b01; ctl_mask = 4'b0100; ctl_dly = 8'd0;
    smp(32'h0, 32'h0, 32'h00FF_0000);
    ctl_valid = 1'b0; ctl_op = 2'b00; ctl_mask = '0;
    chk_cnt("ena_same_edge", 9, 1);
    chk("ena_same_edge_ena", ena, 4'hF);

    ctl(2'b11, 4'h0, 8'd0);
    chk_cnt("clear", 0, 0);
    chk("clear_err", err_sticky, 0);
    chk("clear_ffv", ff_valid, 0);
    chk("clear_fft", ff_time, 0);
    chk("clear_ena", ena, 4'hF);

    ts_save = ts;
    smp(32'h0, 32'h0, 32'hFFFF_0000);
    chk("ch23_ffch", ff_ch, 2);
    smp(32'h0, 32'h0, 32'h0000_00FF);
    chk_cnt("ch0_next", 0, 2);
    chk("ch0_ffch_kept", ff_ch, 2);
    chk("ch0_fft_kept", ff_time, 32'(ts_save));

    // clear wins over a failing sample on the same edge
    ctl_valid = 1'b1; ctl_op = 2'b11;
    smp(32'h0, 32'h0, 32'hFFFF_FFFF);
    ctl_valid = 1'b0; ctl_op = 2'b00;
    chk_cnt("clr_prio", 0, 0);
    chk("clr_prio_err", err_sticky, 0);
    chk("clr_prio_ffv", ff_valid, 0);
    chk("clr_prio_ffch", ff_ch, 0);

    // reset in the middle of a pending off
    smp(32'h0, 32'h0, 32'h0);
    ctl(2'b10, 4'b1111, 8'd3);
    step();
    chk("pre_rst_rdy", ctl_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdy", ctl_ready, 1);
    chk("async_rst_ena", ena, 4'hF);
    chk("async_rst_pass", pass_cnt, 0);
    step(); step();
    rst = 1'b0; ts = 0;
    step(); step(); step(); step();
    chk("rst_wait_ena", ena, 4'hF);
    chk("rst_wait_rdy", ctl_ready, 1);
    ts_save = ts;
    smp(32'h0, 32'h0, 32'hFF00_0000);
    chk("post_rst_fft", ff_time, 32'(ts_save));
    chk("post_rst_ffch", ff_ch, 3);

    // narrow counters: saturation and timestamp wrap
    rst4 = 1'b0; ts4 = 0;
    repeat (15) step();
    smp4 = 1'b1; y4 = 32'h0000_0001;
    step();
    chk("c4_fft15", ff_time4, 15);
    chk("c4_fail1", fail4, 1);
    repeat (19) step();
    chk("c4_sat", fail4, 15);
    chk("c4_pass", pass4, 0);
    smp4 = 1'b0; y4 = '0;
    ctl_valid4 = 1'b1; ctl_op4 = 2'b11;
    step();
    ctl_valid4 = 1'b0; ctl_op4 = 2'b00;
    chk("c4_clear", fail4, 0);
    while (ts4 < 48) step();
    smp4 = 1'b1; y4 = 32'h0000_0100;
    step();
    smp4 = 1'b0; y4 = '0;
    chk("c4_wrap_fft", ff_time4, 0);
    chk("c4_wrap_ffch", ff_ch4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
